// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register, instruction register and return-address stack
// for the fetch stage. JMP/CALL/RET are resolved here with no bubbles.
// Optional macro FETCH_STACK_GUARD_EN compiles in stack overflow/underflow
// detection and the HALT state. Without it, faults saturate the stack pointer.
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [3:0]  OP_JMP      = 4'd4,
  parameter logic [3:0]  OP_CALL     = 4'd5,
  parameter logic [3:0]  OP_RET      = 4'd6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStall,
  input  logic [27:0]       iInstruction,
  output logic [ADDR_W-1:0] oAddress,
  output logic [27:0]       oInstruction,
  output logic              oValid,
  output logic              oError
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [27:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [SP_W-1:0]   sp_dec;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [3:0]        opcode;
  logic              advance;

  assign opcode  = iInstruction[27:24];
  assign target  = ADDR_W'(iInstruction[23:16]);
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign sp_dec  = sp_q - SP_W'(1);
  assign pop_idx = sp_dec[IDX_W-1:0];

`ifdef FETCH_STACK_GUARD_EN
  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t state_q, state_d;
  logic   fault;

  assign advance = (state_q == S_RUN) && !iStall;
  assign oError  = (state_q == S_HALT);
`else
  assign advance = !iStall;
  assign oError  = 1'b0;
`endif

  // Next PC, stack pointer and output register; faulting words are not forwarded.
  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    push_en  = 1'b0;
    push_idx = sp_q[IDX_W-1:0];
`ifdef FETCH_STACK_GUARD_EN
    state_d  = state_q;
    fault    = 1'b0;
`endif
    if (advance) begin
      instr_d = iInstruction;
      valid_d = 1'b1;
      pc_d    = pc_inc;
      case (opcode)
        OP_JMP: pc_d = target;
        OP_CALL: begin
          if (sp_q == SP_FULL) begin
`ifdef FETCH_STACK_GUARD_EN
            fault = 1'b1;
`else
            push_en  = 1'b1;
            push_idx = IDX_W'(STACK_DEPTH - 1);
            pc_d     = target;
`endif
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = target;
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
`ifdef FETCH_STACK_GUARD_EN
            fault = 1'b1;
`else
            pc_d = stack_q[0];
`endif
          end else begin
            sp_d = sp_dec;
            pc_d = stack_q[pop_idx];
          end
        end
        default: ;
      endcase
`ifdef FETCH_STACK_GUARD_EN
      if (fault) begin
        state_d = S_HALT;
        pc_d    = pc_q;
        sp_d    = sp_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        push_en = 1'b0;
      end
`endif
    end
  end

  // Architectural state with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q    <= '0;
      sp_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_STACK_GUARD_EN
      state_q <= S_RUN;
`endif
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef FETCH_STACK_GUARD_EN
      state_q <= state_d;
`endif
    end
  end

  // Return-address storage; contents are not reset.
  always_ff @(posedge Clock) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign oAddress     = pc_q;
  assign oInstruction = instr_q;
  assign oValid       = valid_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and instruction-fetch stage of the mini processor. It drives the address of the combinational instruction ROM and registers the returned 28-bit instruction word for the execute stage. It resolves flow control (JMP, CALL, RET) locally, using a small return-address stack.

## Interface
- `ADDR_W`, 16: PC / ROM address width.
- `STACK_DEPTH`, 4: return-address stack entries (power of two, ≥2).
- `OP_JMP`, 4'd4: opcode of unconditional jump.
- `OP_CALL`, 4'd5: opcode of subroutine call.
- `OP_RET`, 4'd6: opcode of subroutine return.
- `Clock` input 1: system clock, rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `iStall` input 1: execute stage cannot accept; freeze the stage.
- `iInstruction` input 28: word from ROM for `oAddress`.
- `oAddress` output ADDR_W: current PC, combinational from the PC register.
- `oInstruction` output 28: registered instruction to execute.
- `oValid` output 1: `oInstruction` holds a fetched word.
- `oError` output 1: sticky stack overflow/underflow flag.

## Operation
- Instruction fields:
  - opcode = `[27:24]`
  - target = `[23:16]`, zero-extended to ADDR_W
  - `[15:0]` passed through untouched
- States:
  - RUN: normal fetching.
  - HALT: entered on a stack fault; left only by reset.
- RUN, `iStall`=0, each rising edge:
  - `oInstruction` ← `iInstruction`; `oValid` ← 1.
  - Flow-control words are forwarded too; execute treats them as NOPs.
  - Next PC:
    - OP_JMP: PC ← target.
    - OP_CALL: push PC+1, then PC ← target.
    - OP_RET: PC ← popped value (the RET target field is ignored).
    - Otherwise: PC ← PC+1.
- RUN, `iStall`=1: PC, stack, stack pointer, `oInstruction` and `oValid` all hold.
- Stack:
  - `sp` counts from 0 to STACK_DEPTH.
  - Push writes `mem[sp]`, then increments `sp`.
  - Pop decrements `sp`, then reads the new `mem[sp]`.
- Fault conditions:
  - CALL with `sp`=STACK_DEPTH is an overflow.
  - RET with `sp`=0 is an underflow.
  - Fault handling depends on FETCH_STACK_GUARD_EN (see Configuration).
- HALT:
  - `oValid`=0 and `oError`=1.
  - PC, stack and `oInstruction` are frozen; `iStall` is ignored.
- PC arithmetic is modulo 2^ADDR_W; PC=16'hFFFF increments to 0.
- Reset values (asynchronous):
  - PC=0, `sp`=0, state=RUN.
  - `oInstruction`=0, `oValid`=0, `oError`=0.
  - Stack memory contents are don't-care.

## Timing
- `oAddress` changes only on a rising edge; the ROM is combinational, so `iInstruction` is valid in the same cycle.
- Latency from PC to `oInstruction` is 1 cycle.
- Flow control has zero bubbles: the target address is presented in the cycle immediately after JMP/CALL/RET is registered.
- First valid output: `oValid` rises on the first edge after `Reset` is deasserted, carrying `ROM[0]`.
- Reset asserted mid-operation clears all state immediately, including an in-progress stall or HALT.
- Reset is sampled asynchronously; its release must meet recovery time to `Clock`.
- A fault is detected in the cycle the offending word is registered:
  - The faulting CALL/RET word itself is not forwarded.
  - `oValid` is 0 and `oError` is 1 from that edge onward.
- A stall that coincides with a CALL/RET word: neither push, pop, nor fault is evaluated until the edge at which `iStall`=0.

## Configuration
- `FETCH_STACK_GUARD_EN` defined:
  - Overflow/underflow detection and the HALT state are compiled in.
- Undefined:
  - No HALT state; `oError` is tied to 0.
  - On overflow, `sp` stays at STACK_DEPTH, the top entry is overwritten, and the jump is still taken.
  - On underflow, `sp` stays at 0, `mem[0]` is returned, and the jump is taken.

## Test plan
- Reset release, sequential ROM (`NOP`s at 0..3): `oAddress` sequence is 0,1,2,3,4; `oValid`=1 from the first edge; `oInstruction` lags `oAddress` by 1 cycle.
- CALL at addr 3 with target 8, non-flow word at 8, RET at 9: address sequence is 3,8,9,4; `sp` goes 0→1→0; no bubbles.
- JMP at addr 5 with target 5: `oAddress` stays at 5 indefinitely; the JMP word is re-issued every cycle with `oValid`=1.
- `iStall` held high for 3 cycles while a CALL is at `oAddress`: PC, `sp` and `oInstruction` are unchanged for 3 cycles; the push happens on the first unstalled edge.
- Guard enabled: 5 nested CALLs (STACK_DEPTH=4) → on the 5th, `oError`=1 and `oValid`=0 and stay so; RET at reset (`sp`=0) also halts. Guard disabled, same stimulus: `oError`=0, the PC follows the jumps, `sp` stays at 4.
- Reset pulsed mid-subroutine (`sp`=2): `oAddress`=0, `oValid`=0 and `oError`=0 immediately; a subsequent RET with the guard enabled underflows.
